// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display controller.
//   Register addresses, CTRL bit positions and the two fixed segment
//   patterns (all off / all lit, active-low).
package seg7_pkg;

  localparam logic [1:0] ADDR_DIGITS = 2'd0;
  localparam logic [1:0] ADDR_BLANK  = 2'd1;
  localparam logic [1:0] ADDR_BLINK  = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_TEST_BIT = 1;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_ALL = 7'h00;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-7-segment decoder, active-low outputs.
//   iHEX : 4-bit hex value
//   oSEG : segment pattern {g,f,e,d,c,b,a}, 0 = segment lit
module seg7_hex_decode (
  input  logic [3:0] iHEX,
  output logic [6:0] oSEG
);

  always_comb begin
    oSEG = 7'h7F;
    unique case (iHEX)
      4'h0: oSEG = 7'h40;
      4'h1: oSEG = 7'h79;
      4'h2: oSEG = 7'h24;
      4'h3: oSEG = 7'h30;
      4'h4: oSEG = 7'h19;
      4'h5: oSEG = 7'h12;
      4'h6: oSEG = 7'h02;
      4'h7: oSEG = 7'h78;
      4'h8: oSEG = 7'h00;
      4'h9: oSEG = 7'h18;
      4'hA: oSEG = 7'h08;
      4'hB: oSEG = 7'h03;
      4'hC: oSEG = 7'h46;
      4'hD: oSEG = 7'h21;
      4'hE: oSEG = 7'h06;
      4'hF: oSEG = 7'h0E;
    endcase
  end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Bus-facing controller for NUM_DIGITS 7-segment displays.
//   iCLK, iRST_N : clock, async active-low reset
//   iADDR/iWR/iRD/iWDATA/oRDATA : register slave port (read data registered)
//   oSEG   : NUM_DIGITS x 7 active-low patterns, digit d at [7d+6:7d]
//   oFRAME : one-cycle pulse when the refresh pointer wraps
// One shared decoder is walked round-robin over the digits; each result is
// latched into that digit's output register.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [1:0]              iADDR,
  input  logic                    iWR,
  input  logic                    iRD,
  input  logic [31:0]             iWDATA,
  output logic [31:0]             oRDATA,
  output logic [NUM_DIGITS*7-1:0] oSEG,
  output logic                    oFRAME
);

  localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_DIV > 1)  ? $clog2(BLINK_DIV)  : 1;
  localparam logic [PW-1:0] PTR_LAST  = PW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_DIV - 1);

  logic [31:0]                 digitsQ;
  logic [NUM_DIGITS-1:0]       blankQ, blinkQ;
  logic                        enQ, testQ;
  logic [PW-1:0]               ptrQ;
  logic [BW-1:0]               bcntQ;
  logic                        phaseQ;
  logic [NUM_DIGITS-1:0][6:0]  segQ;
  logic                        frameQ;
  logic [31:0]                 rdMux;
  logic [4:0]                  nibLsb;
  logic [6:0]                  hexSeg, decSeg;

  // Register file; a write and a read in the same cycle both happen, the
  // read sampling the pre-write contents.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      digitsQ <= '0;
      blankQ  <= '0;
      blinkQ  <= '0;
      enQ     <= 1'b1;
      testQ   <= 1'b0;
    end else if (iWR) begin
      unique case (iADDR)
        ADDR_DIGITS: digitsQ <= iWDATA;
        ADDR_BLANK:  blankQ  <= iWDATA[NUM_DIGITS-1:0];
        ADDR_BLINK:  blinkQ  <= iWDATA[NUM_DIGITS-1:0];
        ADDR_CTRL: begin
          enQ   <= iWDATA[CTRL_EN_BIT];
          testQ <= iWDATA[CTRL_TEST_BIT];
        end
      endcase
    end
  end

  always_comb begin
    rdMux = '0;
    unique case (iADDR)
      ADDR_DIGITS: rdMux = digitsQ;
      ADDR_BLANK:  rdMux = 32'(blankQ);
      ADDR_BLINK:  rdMux = 32'(blinkQ);
      ADDR_CTRL:   rdMux = {30'd0, testQ, enQ};
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)  oRDATA <= '0;
    else if (iRD) oRDATA <= rdMux;
  end

  // Blink timebase runs regardless of enable.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      bcntQ  <= '0;
      phaseQ <= 1'b0;
    end else if (bcntQ == BCNT_LAST) begin
      bcntQ  <= '0;
      phaseQ <= ~phaseQ;
    end else begin
      bcntQ  <= bcntQ + 1'b1;
    end
  end

  assign nibLsb = 5'(ptrQ) << 2;

  seg7_hex_decode uDec (
    .iHEX (digitsQ[nibLsb +: 4]),
    .oSEG (hexSeg)
  );

  always_comb begin
    decSeg = hexSeg;
    if (testQ)                                   decSeg = SEG_ALL;
    else if (blankQ[ptrQ])                       decSeg = SEG_OFF;
    else if (blinkQ[ptrQ] && phaseQ)             decSeg = SEG_OFF;
  end

  // Scheduler: one digit per enabled cycle; everything holds while disabled.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      segQ   <= '1;
      ptrQ   <= '0;
      frameQ <= 1'b0;
    end else begin
      frameQ <= enQ && (ptrQ == PTR_LAST);
      if (enQ) begin
        segQ[ptrQ] <= decSeg;
        ptrQ       <= (ptrQ == PTR_LAST) ? '0 : ptrQ + 1'b1;
      end
    end
  end

  assign oSEG   = segQ;
  assign oFRAME = frameQ;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl (6 digits, blink half-period 4).
module tb_seg7_display_ctrl;

  localparam int ND = 6;
  localparam int BD = 4;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic [1:0]    iADDR = '0;
  logic          iWR = 1'b0;
  logic          iRD = 1'b0;
  logic [31:0]   iWDATA = '0;
  logic [31:0]   oRDATA;
  logic [ND*7-1:0] oSEG;
  logic          oFRAME;

  seg7_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iADDR(iADDR), .iWR(iWR), .iRD(iRD),
    .iWDATA(iWDATA), .oRDATA(oRDATA), .oSEG(oSEG), .oFRAME(oFRAME)
  );

  always #5 iCLK = ~iCLK;

  int tests = 0;
  int fails = 0;

  // Reference timing state, advanced once per clock edge by tick().
  int ptrM = 0, bcntM = 0;
  bit phM = 0, enM = 1, frameM = 0, ph1M = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    frameM = enM && (ptrM == ND-1);
    if (enM) begin
      if (ptrM == 1) ph1M = phM;
      ptrM = (ptrM + 1) % ND;
    end
    if (bcntM == BD-1) begin bcntM = 0; phM = ~phM; end
    else bcntM++;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    iADDR = a; iWDATA = d; iWR = 1'b1;
    tick();
    iWR = 1'b0;
    if (a == 2'd3) enM = d[0];
  endtask

  task automatic rd(input logic [1:0] a);
    iADDR = a; iRD = 1'b1;
    tick();
    iRD = 1'b0;
  endtask

  function automatic logic [41:0] rep(input logic [6:0] v);
    return {6{v}};
  endfunction

  task automatic modelReset();
    ptrM = 0; bcntM = 0; phM = 0; enM = 1; frameM = 0; ph1M = 0;
  endtask

  logic [41:0] expSeg;
  logic [6:0]  d1Exp;
  bit          seen79, seen7F;
  int          p;

  initial begin
    // ---- reset state ----
    #12;
    chk("rst_seg", oSEG, rep(7'h7F));
    chk("rst_rdata", oRDATA, 32'h0);
    chk("rst_frame", oFRAME, 1'b0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    modelReset();
    #1;
    chk("pre_refresh_seg", oSEG, rep(7'h7F));
    tick();
    chk("first_refresh", oSEG, {rep(7'h7F)} & {35'h7FFFFFFFF, 7'h40});
    chk("frame_1", oFRAME, frameM);
    for (int i = 2; i <= 2*ND; i++) begin
      tick();
      chk($sformatf("frame_%0d", i), oFRAME, frameM);
      if (i == ND)   chk("frame_at_wrap", oFRAME, 1'b1);
      if (i >= ND)   chk($sformatf("zeros_%0d", i), oSEG, rep(7'h40));
    end

    // ---- hex patterns A..F ----
    wr(2'd0, 32'h00FEDCBA);
    ticks(ND);
    chk("hex_AF", oSEG, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08});
    rd(2'd0);
    chk("rd_digits", oRDATA, 32'h00FEDCBA);

    // read and write to the same address together: old value returned
    iADDR = 2'd0; iWDATA = 32'h12888888; iWR = 1'b1; iRD = 1'b1;
    tick();
    iWR = 1'b0; iRD = 1'b0;
    chk("rd_during_wr", oRDATA, 32'h00FEDCBA);

    // ---- blanking, with masked upper bits ----
    wr(2'd1, 32'hFFFFFFC5);
    ticks(ND);
    chk("blank", oSEG, {7'h00, 7'h00, 7'h00, 7'h7F, 7'h00, 7'h7F});
    rd(2'd1);
    chk("rd_blank", oRDATA, 32'h5);
    rd(2'd0);
    chk("rd_digits_full", oRDATA, 32'h12888888);

    // ---- blink on digit 1 ----
    wr(2'd1, 32'h0);
    wr(2'd0, 32'h00000010);
    wr(2'd2, 32'hFFFFFFC2);
    rd(2'd2);
    chk("rd_blink", oRDATA, 32'h2);
    ticks(ND);
    seen79 = 0; seen7F = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      d1Exp  = ph1M ? 7'h7F : 7'h79;
      expSeg = {7'h40, 7'h40, 7'h40, 7'h40, d1Exp, 7'h40};
      chk($sformatf("blink_%0d", i), oSEG, expSeg);
      if (oSEG[13:7] == 7'h79) seen79 = 1;
      if (oSEG[13:7] == 7'h7F) seen7F = 1;
    end
    chk("blink_both_phases", {seen79, seen7F}, 2'b11);

    // ---- test mode overrides blank ----
    wr(2'd1, 32'h3F);
    wr(2'd3, 32'h3);
    ticks(ND);
    chk("test_all_lit", oSEG, rep(7'h00));
    rd(2'd3);
    chk("rd_ctrl_test", oRDATA, 32'h3);

    // ---- disable: freeze ----
    wr(2'd3, 32'hFFFFFFFC);
    rd(2'd3);
    chk("rd_ctrl_off", oRDATA, 32'h0);
    chk("frozen_seg", oSEG, rep(7'h00));
    wr(2'd0, 32'h00777777);
    wr(2'd1, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("frozen_seg_%0d", i), oSEG, rep(7'h00));
      chk($sformatf("frozen_frame_%0d", i), oFRAME, 1'b0);
    end
    wr(2'd3, 32'h1);
    chk("reenable_edge", oSEG, rep(7'h00));
    p = ptrM;
    tick();
    expSeg = rep(7'h00);
    expSeg[p*7 +: 7] = 7'h78;
    chk("resume_ptr", oSEG, expSeg);
    rd(2'd0);
    chk("rd_digits_7", oRDATA, 32'h00777777);
    wr(2'd2, 32'h3F);
    ticks(3);

    // ---- asynchronous reset mid-frame / mid-blink ----
    @(posedge iCLK);
    #3 iRST_N = 1'b0;
    #1;
    chk("midrst_seg", oSEG, rep(7'h7F));
    chk("midrst_frame", oFRAME, 1'b0);
    chk("midrst_rdata", oRDATA, 32'h0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    modelReset();
    #1;
    rd(2'd3);
    chk("midrst_ctrl", oRDATA, 32'h1);
    rd(2'd0);
    chk("midrst_digits", oRDATA, 32'h0);
    rd(2'd1);
    chk("midrst_blank", oRDATA, 32'h0);
    rd(2'd2);
    chk("midrst_blink", oRDATA, 32'h0);
    chk("midrst_refresh", oSEG, {7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
- Bus-facing controller for a bank of NUM_DIGITS 7-segment displays (HEX0..HEX5 on the board).
- Holds digit, blank, blink and control registers written from an Avalon-MM style slave port.
- Time-shares one hex-to-segment decoder round-robin across all digits. Each digit's decoded pattern lands in a per-digit output register.
- Sits between the HPS/FPGA bridge and the board segment pins, and replaces per-digit LUT instances.

Parameters:
- NUM_DIGITS, 6, number of displays driven; legal range 1..8.
- BLINK_DIV, 12500000, clock cycles per blink half-period; minimum 1. 12500000 gives 2 Hz at 50 MHz.

Ports:
- iCLK  in  1  system clock; all logic rising-edge.
- iRST_N  in  1  asynchronous active-low reset.
- iADDR  in  2  register address.
- iWR  in  1  write strobe, single cycle.
- iRD  in  1  read strobe, single cycle.
- iWDATA  in  32  write data.
- oRDATA  out  32  read data, registered.
- oSEG  out  NUM_DIGITS*7  segment patterns, active-low; digit d occupies bits [7d+6:7d]; segment order {g,f,e,d,c,b,a}.
- oFRAME  out  1  one-cycle pulse when the refresh pointer wraps.

Behaviour:
- Reset: iRST_N, asynchronous, active-low; clock iCLK. Reset is honoured at any time, including mid-frame; no partial state survives.
- Reset values:
  - DIGITS=0, BLANK=0, BLINK=0, CTRL=32'h1 (enable=1, test=0).
  - Refresh pointer=0, blink counter=0, blink phase=0.
  - oSEG all ones (all segments off), oRDATA=0, oFRAME=0.
- Register map:
  - 0 DIGITS[31:0]: nibble d = hex value of digit d. Stored and read back in full, including nibbles at or above NUM_DIGITS.
  - 1 BLANK[NUM_DIGITS-1:0]: 1 forces digit dark.
  - 2 BLINK[NUM_DIGITS-1:0]: 1 makes digit dark while blink phase=1.
  - 3 CTRL: bit0 enable, bit1 test (all segments lit). Other bits write-ignored, read 0.
  - Mask bits above NUM_DIGITS-1 are write-ignored and read 0.
- Write: the register updates on the iCLK edge where iWR=1.
- Read: oRDATA is valid the cycle after iRD=1 and holds its value until the next read. A simultaneous write to the same address returns the old value.
- iWR and iRD together: both are performed.
- Refresh scheduler, when enable=1, each cycle:
  - Decode digit ptr and register the result into seg[ptr].
  - Advance ptr; ptr wraps from NUM_DIGITS-1 to 0.
  - On that wrap, oFRAME=1 for exactly one cycle.
- Decode priority for digit d, highest first:
  - test → 7'h00.
  - BLANK[d] → 7'h7F.
  - BLINK[d] and phase=1 → 7'h7F.
  - Otherwise standard hex pattern: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→18, A→08, b→03, C→46, d→21, E→06, F→0E.
- Latency: any register change is visible on digit d's oSEG 1..NUM_DIGITS cycles after the write edge. A write coinciding with decode of the same digit uses the pre-write value; the new value appears next pass.
- enable=0: ptr, outputs and oFRAME freeze (oFRAME=0). The blink counter keeps running. Re-enable resumes from the frozen ptr.
- Blink counter: counts 0..BLINK_DIV-1. On wrap it returns to 0 and phase toggles. BLINK_DIV=1 toggles phase every cycle.
- NUM_DIGITS=1: ptr stays 0 and oFRAME pulses every enabled cycle.

Decomposition:
- Package seg7_pkg holds:
  - register address constants ADDR_DIGITS/ADDR_BLANK/ADDR_BLINK/ADDR_CTRL;
  - CTRL bit indices;
  - SEG_OFF=7'h7F and SEG_ALL=7'h00.
- One combinational sub-module, seg7_hex_decode (4-bit in, 7-bit active-low out), instantiated once and shared by the scheduler.

Test Plan:
- Reset then run 2*NUM_DIGITS cycles → oSEG all 7'h7F until first refresh; after one frame all digits 7'h40 (value 0); oFRAME pulses every 6 cycles.
- Write DIGITS=32'h00FEDCBA → within 6 cycles oSEG digits 0..5 = 08,03,46,21,06,0E; read addr 0 next cycle → 32'h00FEDCBA.
- BLANK=6'b000101 with DIGITS=32'h00888888 → digits 0,2 = 7'h7F, others 7'h00; read addr 1 → 32'h5.
- BLINK_DIV=4, BLINK=6'b000010, DIGITS digit1=1 → digit1 alternates 7'h79 / 7'h7F every 4 cycles (±6 cycle refresh skew); other digits steady.
- CTRL=2'b11 with BLANK=6'h3F → all digits 7'h00; then CTRL=0 → oSEG and ptr frozen, oFRAME held 0; a DIGITS write causes no change until CTRL=1.
- Assert iRST_N low mid-frame and mid-blink → immediate oSEG all 7'h7F, registers at reset values, CTRL reads 32'h1.
